alu: RTL and testbench
======================

Name: alu

Overview:
- Registered 16-function arithmetic/logic unit operating on two unsigned OPER_WIDTH-bit operands.
- Produces an OUT_WIDTH-bit result with a one-cycle latency, qualified by OUT_VALID.
- Sits in the system datapath; the controller drives operands, opcode and EN and samples the result one clock later.

Parameters:
- OPER_WIDTH, 8, operand width in bits.
- OUT_WIDTH, 2*OPER_WIDTH (16), result width in bits; must be >= 2*OPER_WIDTH so the full product fits.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-low reset.
- A  input  OPER_WIDTH  operand A, unsigned.
- B  input  OPER_WIDTH  operand B, unsigned.
- EN  input  1  operation enable, sampled on the rising edge.
- ALU_FUN  input  4  opcode.
- ALU_OUT  output  OUT_WIDTH  registered result.
- OUT_VALID  output  1  high for each cycle in which ALU_OUT holds a result computed from an enabled cycle.

Behaviour:
- Reset: on a rising CLK edge with RST=0, ALU_OUT<=0 and OUT_VALID<=0. Reset has priority over EN and takes effect mid-operation with no residual state.
- Latency: A, B and ALU_FUN are sampled at rising edge N with EN=1. The result appears on ALU_OUT with OUT_VALID=1 after edge N, so it is stable one cycle after input setup.
- Back-to-back operation: a new result is produced every cycle while EN=1. No handshake or backpressure.
- EN=0 at an edge: ALU_OUT<=0, OUT_VALID<=0.
- All operands are unsigned. Every result is zero-extended to OUT_WIDTH unless stated otherwise.
- Opcodes:
  - 0000 ADD: A+B, with the carry landing in bit OPER_WIDTH.
  - 0001 SUB: A-B modulo 2^OUT_WIDTH. A negative result is two's complement across all OUT_WIDTH bits, e.g. 3-7 = 16'hFFFC.
  - 0010 MUL: full A*B product.
  - 0011 DIV: integer quotient A/B. If B==0 the result is 0.
  - 0100 AND: A&B.
  - 0101 OR: A|B.
  - 0110 NAND: ~(A&B), an OPER_WIDTH-bit result; upper bits 0.
  - 0111 NOR: ~(A|B), OPER_WIDTH-bit; upper bits 0.
  - 1000 XOR: A^B.
  - 1001 XNOR: ~(A^B), OPER_WIDTH-bit; upper bits 0.
  - 1010 EQ: 1 if A==B, else 0.
  - 1011 GT: 1 if A>B, else 0.
  - 1100 LT: 1 if A<B, else 0.
  - 1101 SHR: A>>1, logical; B is ignored.
  - 1110 SHL: A<<1, computed at OUT_WIDTH width so the shifted-out MSB is retained in bit OPER_WIDTH. B is ignored.
  - 1111: result 0, but OUT_VALID still follows EN.
- Unknown or X opcode handling is not required beyond the 1111 rule.
- Comparisons set only bit 0; all other bits are 0.

Decomposition:
- Shared package:
  - opcode localparams for the 16 ALU_FUN codes (ALU_ADD ... ALU_SHL, ALU_NOP=4'hF);
  - default widths OPER_WIDTH=8 and OUT_WIDTH=16.
- Optional sub-module alu_comb: purely combinational opcode decode and result compute. The top level adds the output and valid registers.
- A single-module implementation is also acceptable.

Test Plan:
- Reset: hold RST=0 for 2 cycles with EN=1 and A=15, B=3, ALU_FUN=0 -> ALU_OUT=0, OUT_VALID=0. Release RST -> 18 is valid one cycle later.
- Arithmetic sweep, EN=1, one opcode per cycle:
  - 15+3 -> 18; 15-3 -> 12; 3-7 -> 16'hFFFC;
  - 255+255 -> 510; 6*5 -> 30; 255*255 -> 65025;
  - 12/4 -> 3; 7/0 -> 0.
  - OUT_VALID=1 every cycle.
- Logic sweep:
  - F0&0F -> 0; F0|0F -> 00FF;
  - AA nand 55 -> 00FF; AA nor 55 -> 0000;
  - AA^55 -> 00FF; AA xnor 55 -> 0000.
- Compare and shift:
  - EQ(8,8)=1, EQ(8,9)=0; GT(9,5)=1, GT(5,9)=0; LT(3,7)=1, LT(7,7)=0;
  - SHR(16)=8; SHL(16)=32; SHL(8'h80)=16'h0100; opcode 1111 -> 0.
- Enable/reset interaction:
  - drop EN to 0 -> next edge ALU_OUT=0, OUT_VALID=0;
  - assert RST=0 while EN=1 mid-stream -> outputs clear on that edge; after release, results resume with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: default datapath widths and the ALU_FUN opcode map.
package alu_pkg;

   localparam int DEF_OPER_WIDTH = 8;
   localparam int DEF_OUT_WIDTH  = 2 * DEF_OPER_WIDTH;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_MUL  = 4'h2;
   localparam logic [3:0] ALU_DIV  = 4'h3;
   localparam logic [3:0] ALU_AND  = 4'h4;
   localparam logic [3:0] ALU_OR   = 4'h5;
   localparam logic [3:0] ALU_NAND = 4'h6;
   localparam logic [3:0] ALU_NOR  = 4'h7;
   localparam logic [3:0] ALU_XOR  = 4'h8;
   localparam logic [3:0] ALU_XNOR = 4'h9;
   localparam logic [3:0] ALU_EQ   = 4'hA;
   localparam logic [3:0] ALU_GT   = 4'hB;
   localparam logic [3:0] ALU_LT   = 4'hC;
   localparam logic [3:0] ALU_SHR  = 4'hD;
   localparam logic [3:0] ALU_SHL  = 4'hE;
   localparam logic [3:0] ALU_NOP  = 4'hF;

endpackage

// File: rtl/alu_comb.sv
// Combinational opcode decode and result compute for the ALU; no state.
module alu_comb
   import alu_pkg::*;
#(
   parameter int OPER_WIDTH = DEF_OPER_WIDTH,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
   input  logic [OPER_WIDTH-1:0] a_i,
   input  logic [OPER_WIDTH-1:0] b_i,
   input  logic [3:0]            alu_fun_i,
   output logic [OUT_WIDTH-1:0]  result_o
);

   localparam int PAD_W = OUT_WIDTH - OPER_WIDTH;

   logic [OUT_WIDTH-1:0] a_ext;
   logic [OUT_WIDTH-1:0] b_ext;

   // Operands are widened first so carry, borrow, product and SHL's top bit survive.
   assign a_ext = {{PAD_W{1'b0}}, a_i};
   assign b_ext = {{PAD_W{1'b0}}, b_i};

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      result_o = '0;
      case (alu_fun_i)
         ALU_ADD:  result_o = a_ext + b_ext;
         ALU_SUB:  result_o = a_ext - b_ext;
         ALU_MUL:  result_o = a_ext * b_ext;
         ALU_DIV:  result_o = (b_i == '0) ? '0 : a_ext / b_ext;
         ALU_AND:  result_o = a_ext & b_ext;
         ALU_OR:   result_o = a_ext | b_ext;
         ALU_NAND: result_o = {{PAD_W{1'b0}}, ~(a_i & b_i)};
         ALU_NOR:  result_o = {{PAD_W{1'b0}}, ~(a_i | b_i)};
         ALU_XOR:  result_o = a_ext ^ b_ext;
         ALU_XNOR: result_o = {{PAD_W{1'b0}}, ~(a_i ^ b_i)};
         ALU_EQ:   result_o = {{(OUT_WIDTH-1){1'b0}}, a_i == b_i};
         ALU_GT:   result_o = {{(OUT_WIDTH-1){1'b0}}, a_i > b_i};
         ALU_LT:   result_o = {{(OUT_WIDTH-1){1'b0}}, a_i < b_i};
         ALU_SHR:  result_o = a_ext >> 1;
         ALU_SHL:  result_o = a_ext << 1;
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Registered 16-function ALU: one-cycle latency, result qualified by OUT_VALID.
module alu
   import alu_pkg::*;
#(
   parameter int OPER_WIDTH = DEF_OPER_WIDTH,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [OPER_WIDTH-1:0] A,
   input  logic [OPER_WIDTH-1:0] B,
   input  logic                  EN,
   input  logic [3:0]            ALU_FUN,
   output logic [OUT_WIDTH-1:0]  ALU_OUT,
   output logic                  OUT_VALID
);

   logic [OUT_WIDTH-1:0] alu_out_d;
   logic [OUT_WIDTH-1:0] alu_out_q;
   logic                 out_valid_q;

   alu_comb #(
      .OPER_WIDTH (OPER_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_alu_comb (
      .a_i       (A),
      .b_i       (B),
      .alu_fun_i (ALU_FUN),
      .result_o  (alu_out_d)
   );

   // Reset outranks EN; a disabled cycle clears the result rather than holding it.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments for all registered state.
      if (!RST) begin
         alu_out_q   <= '0;
         out_valid_q <= 1'b0;
      end else if (EN) begin
         alu_out_q   <= alu_out_d;
         out_valid_q <= 1'b1;
      end else begin
         alu_out_q   <= '0;
         out_valid_q <= 1'b0;
      end
   end

   assign ALU_OUT   = alu_out_q;
   assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal checks plus randomized traffic against a behavioural model.
module tb_alu;

   logic        CLK;
   logic        RST;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        EN;
   logic [3:0]  ALU_FUN;
   logic [15:0] ALU_OUT;
   logic        OUT_VALID;

   int errors = 0;
   int checks = 0;

   // Expected outputs after the most recent rising edge, from the model.
   int exp_out;
   int exp_valid;
   bit have_exp = 0;

   alu #(
      .OPER_WIDTH (8),
      .OUT_WIDTH  (16)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .A         (A),
      .B         (B),
      .EN        (EN),
      .ALU_FUN   (ALU_FUN),
      .ALU_OUT   (ALU_OUT),
      .OUT_VALID (OUT_VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Plain-arithmetic reading of the opcode table on unsigned 8-bit operands, 16-bit result.
   function automatic int model(input int f, input int a, input int b);
      int r;
      case (f)
         0:  r = a + b;
         1:  r = (a - b) & 'hFFFF;
         2:  r = a * b;
         3:  r = (b == 0) ? 0 : a / b;
         4:  r = a & b;
         5:  r = a | b;
         6:  r = 255 - (a & b);
         7:  r = 255 - (a | b);
         8:  r = a ^ b;
         9:  r = 255 - (a ^ b);
         10: r = (a == b) ? 1 : 0;
         11: r = (a > b) ? 1 : 0;
         12: r = (a < b) ? 1 : 0;
         13: r = a / 2;
         14: r = a * 2;
         default: r = 0;
      endcase
      return r;
   endfunction

   always @(posedge CLK) begin
      if (!RST) begin
         exp_out   = 0;
         exp_valid = 0;
      end else if (EN) begin
         exp_out   = model(int'(ALU_FUN), int'(A), int'(B));
         exp_valid = 1;
      end else begin
         exp_out   = 0;
         exp_valid = 0;
      end
      have_exp = 1;
   end

   always @(negedge CLK) begin
      if (have_exp) begin
         check("model_out", int'(ALU_OUT), exp_out);
         check("model_valid", int'(OUT_VALID), exp_valid);
      end
   end

   // Apply one operation and check the result a cycle later against a hand-computed value.
   task automatic do_op(input string name, input logic [3:0] f, input int a, input int b,
                        input int expected);
      ALU_FUN = f;
      A       = 8'(a);
      B       = 8'(b);
      EN      = 1'b1;
      @(negedge CLK);
      check(name, int'(ALU_OUT), expected);
      check({name, "_valid"}, int'(OUT_VALID), 1);
      check({name, "_model"}, model(int'(f), a, b), expected);
   endtask

   initial begin
      RST     = 1'b0;
      EN      = 1'b1;
      A       = 8'd15;
      B       = 8'd3;
      ALU_FUN = 4'h0;

      repeat (2) @(negedge CLK);
      check("reset_out", int'(ALU_OUT), 0);
      check("reset_valid", int'(OUT_VALID), 0);

      RST = 1'b1;
      @(negedge CLK);
      check("post_reset_out", int'(ALU_OUT), 18);
      check("post_reset_valid", int'(OUT_VALID), 1);

      do_op("add_15_3",    4'h0, 15,  3,   18);
      do_op("sub_15_3",    4'h1, 15,  3,   12);
      do_op("sub_3_7",     4'h1, 3,   7,   'hFFFC);
      do_op("add_255_255", 4'h0, 255, 255, 510);
      do_op("mul_6_5",     4'h2, 6,   5,   30);
      do_op("mul_255_255", 4'h2, 255, 255, 65025);
      do_op("div_12_4",    4'h3, 12,  4,   3);
      do_op("div_7_0",     4'h3, 7,   0,   0);

      do_op("and",  4'h4, 'hF0, 'h0F, 'h0000);
      do_op("or",   4'h5, 'hF0, 'h0F, 'h00FF);
      do_op("nand", 4'h6, 'hAA, 'h55, 'h00FF);
      do_op("nor",  4'h7, 'hAA, 'h55, 'h0000);
      do_op("xor",  4'h8, 'hAA, 'h55, 'h00FF);
      do_op("xnor", 4'h9, 'hAA, 'h55, 'h0000);

      do_op("eq_8_8",   4'hA, 8,    8,   1);
      do_op("eq_8_9",   4'hA, 8,    9,   0);
      do_op("gt_9_5",   4'hB, 9,    5,   1);
      do_op("gt_5_9",   4'hB, 5,    9,   0);
      do_op("lt_3_7",   4'hC, 3,    7,   1);
      do_op("lt_7_7",   4'hC, 7,    7,   0);
      do_op("shr_16",   4'hD, 16,   99,  8);
      do_op("shl_16",   4'hE, 16,   99,  32);
      do_op("shl_80",   4'hE, 'h80, 0,   'h0100);
      do_op("nop",      4'hF, 'hFF, 'hFF, 0);

      EN = 1'b0;
      @(negedge CLK);
      check("en_off_out", int'(ALU_OUT), 0);
      check("en_off_valid", int'(OUT_VALID), 0);

      do_op("resume_add", 4'h0, 100, 28, 128);
      RST = 1'b0;
      EN  = 1'b1;
      @(negedge CLK);
      check("mid_reset_out", int'(ALU_OUT), 0);
      check("mid_reset_valid", int'(OUT_VALID), 0);
      RST = 1'b1;
      do_op("after_reset_mul", 4'h2, 12, 12, 144);

      // Randomized traffic with occasional disable/reset; operands biased toward 0 and 255.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 5))
            0:       A = 8'h00;
            1:       A = 8'hFF;
            default: A = 8'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0:       B = 8'h00;
            1:       B = 8'hFF;
            default: B = 8'($urandom);
         endcase
         ALU_FUN = 4'($urandom);
         EN      = ($urandom_range(0, 9) != 0);
         RST     = ($urandom_range(0, 29) != 0);
         @(negedge CLK);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
